// File: rtl/bpu_update_scheduler.sv
// Branch predictor update scheduler.
// Resolved-branch updates are queued in a small FIFO and written into the
// single-ported BHT/BTB only when fetch is not reading. If the FIFO fills, or
// if its head has been held back by lookups for MAX_WAIT cycles, fetch is
// stalled so that one queued update can be written.
module bpu_update_scheduler #(
   parameter int DEPTH    = 4,
   parameter int IDX_W    = 3,
   parameter int MAX_WAIT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     upd_valid,
   input  logic                     upd_wen_btb,
   input  logic [15:0]              upd_pc,
   input  logic                     upd_taken,
   input  logic [15:0]              upd_target,
   output logic                     upd_ready,
   input  logic                     lookup_req,
   input  logic [IDX_W-1:0]         lookup_idx,
   output logic                     lookup_grant,
   output logic                     fetch_stall,
   output logic                     mem_en,
   output logic                     mem_bht_we,
   output logic                     mem_btb_we,
   output logic [IDX_W-1:0]         mem_idx,
   output logic                     mem_taken,
   output logic [15:0]              mem_target,
   output logic [$clog2(DEPTH):0]   pending_cnt
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      FORCE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   // Update queue storage; data words need no reset because count gates them.
   logic [IDX_W-1:0]  fifo_idx    [DEPTH];
   logic              fifo_taken  [DEPTH];
   logic              fifo_wen_btb[DEPTH];
   logic [15:0]       fifo_target [DEPTH];

   logic push, pop, grant;

   // Only pc[IDX_W:1] selects a table entry; the remaining bits are dropped.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{upd_pc[15:IDX_W+1], upd_pc[0]};

   // upd_ready is held low while reset is asserted, even though the queue is empty.
   assign upd_ready = rst_n & (count_q != FULL_CNT);
   assign push      = upd_valid & upd_ready;
   // The state guarantees a non-empty queue whenever SERVE or FORCE is active.
   assign pop       = (state_q == FORCE) | ((state_q == SERVE) & ~lookup_req);
   assign grant     = rst_n & lookup_req & ((state_q == IDLE) | (state_q == SERVE));

   // Next occupancy, head wait time and scheduling mode.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end

      if (pop || count_q == '0) begin
         wait_d = '0;
      end else if (wait_q != WAIT_LIM) begin
         wait_d = wait_q + 1'b1;
      end else begin
         wait_d = wait_q;
      end

      if (count_d == '0) begin
         state_d = IDLE;
      end else if (count_d == FULL_CNT || wait_d == WAIT_LIM) begin
         state_d = FORCE;
      end else begin
         state_d = SERVE;
      end
   end

   // Control state: pointers, occupancy, wait counter and mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wait_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wait_q  <= wait_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Capture an accepted update at the tail slot.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_idx[wr_ptr_q]     <= upd_pc[IDX_W:1];
         fifo_taken[wr_ptr_q]   <= upd_taken;
         fifo_wen_btb[wr_ptr_q] <= upd_wen_btb;
         fifo_target[wr_ptr_q]  <= upd_target;
      end
   end

   // Memory port mux: a head write wins over the fetch read when scheduled.
   always_comb begin
      mem_en     = 1'b0;
      mem_bht_we = 1'b0;
      mem_btb_we = 1'b0;
      mem_idx    = '0;
      mem_taken  = 1'b0;
      mem_target = '0;
      if (pop) begin
         mem_en     = 1'b1;
         mem_bht_we = 1'b1;
         mem_btb_we = fifo_wen_btb[rd_ptr_q];
         mem_idx    = fifo_idx[rd_ptr_q];
         mem_taken  = fifo_taken[rd_ptr_q];
         mem_target = fifo_target[rd_ptr_q];
      end else if (grant) begin
         mem_en  = 1'b1;
         mem_idx = lookup_idx;
      end
   end

   assign lookup_grant = grant;
   assign fetch_stall  = (state_q == FORCE) & lookup_req;
   assign pending_cnt  = count_q;

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Self-checking bench for bpu_update_scheduler: directed scenarios followed by
// random traffic, all compared each cycle against a queue-based reference.
module tb_bpu_update_scheduler;

   localparam int DEPTH    = 4;
   localparam int IDX_W    = 3;
   localparam int MAX_WAIT = 4;

   logic              clk;
   logic              rst_n;
   logic              upd_valid;
   logic              upd_wen_btb;
   logic [15:0]       upd_pc;
   logic              upd_taken;
   logic [15:0]       upd_target;
   logic              upd_ready;
   logic              lookup_req;
   logic [IDX_W-1:0]  lookup_idx;
   logic              lookup_grant;
   logic              fetch_stall;
   logic              mem_en;
   logic              mem_bht_we;
   logic              mem_btb_we;
   logic [IDX_W-1:0]  mem_idx;
   logic              mem_taken;
   logic [15:0]       mem_target;
   logic [2:0]        pending_cnt;

   bpu_update_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .upd_valid    (upd_valid),
      .upd_wen_btb  (upd_wen_btb),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_target   (upd_target),
      .upd_ready    (upd_ready),
      .lookup_req   (lookup_req),
      .lookup_idx   (lookup_idx),
      .lookup_grant (lookup_grant),
      .fetch_stall  (fetch_stall),
      .mem_en       (mem_en),
      .mem_bht_we   (mem_bht_we),
      .mem_btb_we   (mem_btb_we),
      .mem_idx      (mem_idx),
      .mem_taken    (mem_taken),
      .mem_target   (mem_target),
      .pending_cnt  (pending_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending updates in arrival order, head-blocked age, mode.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
      logic             wen;
      logic [15:0]      tgt;
   } ent_t;

   localparam int M_IDLE  = 0;
   localparam int M_SERVE = 1;
   localparam int M_FORCE = 2;

   ent_t q[$];
   int   blocked;
   int   mode;
   int   n_vec;
   int   n_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_write();
      return (mode == M_FORCE) || (mode == M_SERVE && !lookup_req);
   endfunction

   task automatic check_outputs();
      bit   wr;
      bit   gr;
      ent_t h;
      wr = model_write();
      gr = lookup_req && (mode != M_FORCE);
      h  = '0;
      if (wr) h = q[0];
      check_eq("mem_en",     32'(mem_en),       32'(wr || gr));
      check_eq("bht_we",     32'(mem_bht_we),   32'(wr));
      check_eq("btb_we",     32'(mem_btb_we),   32'(wr && h.wen));
      check_eq("mem_idx",    32'(mem_idx),      wr ? 32'(h.idx) : (gr ? 32'(lookup_idx) : 32'd0));
      check_eq("mem_taken",  32'(mem_taken),    32'(wr && h.taken));
      check_eq("mem_target", 32'(mem_target),   wr ? 32'(h.tgt) : 32'd0);
      check_eq("grant",      32'(lookup_grant), 32'(gr));
      check_eq("stall",      32'(fetch_stall),  32'(lookup_req && mode == M_FORCE));
      check_eq("upd_ready",  32'(upd_ready),    32'(q.size() < DEPTH));
      check_eq("pending",    32'(pending_cnt),  32'(q.size()));
      if (wr)
         $display("t=%0t write idx=%0d taken=%0b btb_we=%0b target=%04h pending=%0d",
                  $time, h.idx, h.taken, h.wen, h.tgt, q.size());
   endtask

   // Advance the model over one clock edge using the inputs currently driven.
   task automatic model_step();
      bit   wr;
      int   old;
      ent_t e;
      wr  = model_write();
      old = q.size();
      if (wr) e = q.pop_front();
      if (upd_valid && old < DEPTH) begin
         e.idx   = upd_pc[IDX_W:1];
         e.taken = upd_taken;
         e.wen   = upd_wen_btb;
         e.tgt   = upd_target;
         q.push_back(e);
      end
      if (wr || old == 0) blocked = 0;
      else if (blocked < MAX_WAIT) blocked++;
      if (q.size() == 0) mode = M_IDLE;
      else if (q.size() == DEPTH || blocked == MAX_WAIT) mode = M_FORCE;
      else mode = M_SERVE;
   endtask

   task automatic cycle(input logic v, input logic wb, input logic [15:0] pc, input logic tk,
                        input logic [15:0] tg, input logic lr, input logic [IDX_W-1:0] li);
      @(negedge clk);
      upd_valid   = v;
      upd_wen_btb = wb;
      upd_pc      = pc;
      upd_taken   = tk;
      upd_target  = tg;
      lookup_req  = lr;
      lookup_idx  = li;
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
   endtask

   // Assert reset part-way through a cycle with fetch requesting, then release.
   task automatic pulse_reset();
      @(negedge clk);
      upd_valid  = 1'b0;
      lookup_req = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mem_en",  32'(mem_en),       32'd0);
      check_eq("rst_ready",   32'(upd_ready),    32'd0);
      check_eq("rst_pending", 32'(pending_cnt),  32'd0);
      check_eq("rst_grant",   32'(lookup_grant), 32'd0);
      check_eq("rst_bht_we",  32'(mem_bht_we),   32'd0);
      check_eq("rst_stall",   32'(fetch_stall),  32'd0);
      $display("t=%0t reset asserted, %0d entries discarded", $time, q.size());
      q.delete();
      blocked = 0;
      mode    = M_IDLE;
      @(negedge clk);
      lookup_req = 1'b0;
      rst_n      = 1'b1;
      #1;
      check_eq("rel_ready",   32'(upd_ready),   32'd1);
      check_eq("rel_mem_en",  32'(mem_en),      32'd0);
      check_eq("rel_pending", 32'(pending_cnt), 32'd0);
   endtask

   initial begin
      int lr_pct;
      n_vec   = 0;
      n_err   = 0;
      blocked = 0;
      mode    = M_IDLE;
      rst_n       = 1'b0;
      upd_valid   = 1'b0;
      upd_wen_btb = 1'b0;
      upd_pc      = '0;
      upd_taken   = 1'b0;
      upd_target  = '0;
      lookup_req  = 1'b1;
      lookup_idx  = 3'd6;

      // Outputs during power-on reset, with fetch already requesting.
      #3;
      check_eq("por_mem_en", 32'(mem_en),       32'd0);
      check_eq("por_grant",  32'(lookup_grant), 32'd0);
      check_eq("por_ready",  32'(upd_ready),    32'd0);
      check_eq("por_midx",   32'(mem_idx),      32'd0);
      @(negedge clk);
      @(negedge clk);
      lookup_req = 1'b0;
      rst_n      = 1'b1;
      #1;
      check_eq("rel_ready0",   32'(upd_ready),   32'd1);
      check_eq("rel_pending0", 32'(pending_cnt), 32'd0);

      // Single update with no lookups: written the following cycle.
      cycle(1, 1, 16'h0006, 1, 16'h0020, 0, 0);
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);

      // Continuous lookups starve the head until the wait limit forces a write.
      cycle(1, 0, 16'h0004, 1, 16'h1234, 1, 3'd5);
      for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 0, 1, 3'(k));

      // Overfill with lookups active: fifth update is held until space frees.
      for (int k = 0; k < 7; k++) begin
         int p;
         p = (k < 4) ? k : 4;
         cycle(1, 1'(p), 16'(2 * p + 2), 1'(~p), 16'(16'hA000 + p), 1, 3'(k));
      end
      for (int k = 0; k < 12; k++) cycle(0, 0, 0, 0, 0, 1, 3'(k));
      repeat (6) cycle(0, 0, 0, 0, 0, 0, 0);

      // Simultaneous push and pop at count 2, continuing across pointer wrap.
      cycle(1, 1, 16'h0002, 1, 16'hB001, 1, 1);
      cycle(1, 0, 16'h0004, 0, 16'hB002, 1, 2);
      for (int k = 0; k < 4; k++) cycle(1, 1'(k), 16'(4 * k + 6), 1'(k), 16'(16'hB003 + k), 0, 0);
      repeat (6) cycle(0, 0, 0, 0, 0, 0, 0);

      // BHT-only update with the highest index.
      cycle(1, 0, 16'h000E, 0, 16'hBEEF, 0, 0);
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);

      // Reset with entries pending: none of them may be written afterwards.
      for (int k = 0; k < 3; k++) cycle(1, 1, 16'(2 * k + 2), 1, 16'(16'hC000 + k), 1, 3'(k));
      pulse_reset();
      repeat (8) cycle(0, 0, 0, 0, 0, 0, 0);

      // Random traffic with lookup pressure varied per segment.
      lr_pct = 50;
      for (int i = 0; i < 1200; i++) begin
         if (i % 100 == 0) lr_pct = 10 + 40 * int'($urandom_range(0, 2));
         if (i % 500 == 250) pulse_reset();
         cycle(1'($urandom_range(0, 99) < 45), 1'($urandom), 16'($urandom), 1'($urandom),
               16'($urandom), 1'($urandom_range(0, 99) < lr_pct), 3'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bpu_update_scheduler.md
Name: bpu_update_scheduler

Overview:
Sequences writes into the single-ported branch predictor tables (BHT + BTB) so fetch lookups and decode-stage branch resolution never collide.
Resolution updates from branch control (wen_BHT, wen_BTB, taken, actual target) are buffered in a small FIFO. Queued updates drain into the tables in idle lookup slots.
Fetch lookups have priority, and a starvation/full guard forces drains by stalling fetch.
The block sits between branch control in decode, the fetch-stage predictor lookup, and the predictor memory.

Parameters:
DEPTH, 4, update FIFO entries (power of 2, >=2)
IDX_W, 3, predictor table index width; index = pc[IDX_W:1]
MAX_WAIT, 4, max cycles the FIFO head may be blocked by lookups before a forced drain (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
upd_valid  in  1  resolved branch update request (driven by wen_BHT)
upd_wen_btb  in  1  update also writes the BTB (wen_BTB)
upd_pc  in  16  PC of the resolved branch
upd_taken  in  1  actual branch outcome
upd_target  in  16  actual target address
upd_ready  out  1  FIFO can accept; decode stalls on upd_valid & ~upd_ready
lookup_req  in  1  fetch requests a predictor read
lookup_idx  in  IDX_W  fetch read index
lookup_grant  out  1  read owns the memory port this cycle
fetch_stall  out  1  lookup_req denied this cycle
mem_en  out  1  memory port enable
mem_bht_we  out  1  BHT write this cycle
mem_btb_we  out  1  BTB write this cycle
mem_idx  out  IDX_W  read or write index
mem_taken  out  1  BHT write data
mem_target  out  16  BTB write data
pending_cnt  out  clog2(DEPTH)+1  entries queued

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, pointers, count and wait_cnt cleared, state=IDLE. All outputs are 0 while rst_n=0, including upd_ready. After release: upd_ready=1 and the rest are 0 until requests arrive. Entries pending at reset are discarded and never written.
- Push: on upd_valid & upd_ready at the clock edge, {upd_pc[IDX_W:1], upd_taken, upd_wen_btb, upd_target} goes to the tail. upd_ready = (count != DEPTH). A push is refused when full, even if a pop happens in the same cycle.
- Latency: a pushed entry is written no earlier than the cycle after the push. There is no bypass from upd_* to mem_*.
- Pop: a write cycle drives the head: mem_en=1, mem_bht_we=1, mem_btb_we=head.wen_btb, mem_idx/mem_taken/mem_target from the head. The head is popped at the edge. mem_target is don't-care-free and equals the stored value even when mem_btb_we=0.
- Push and pop in the same cycle: count is unchanged and FIFO order is preserved. Pointers wrap modulo DEPTH.
- Read cycle: mem_en=1, mem_idx=lookup_idx, lookup_grant=1, no write enables.
- wait_cnt rules:
  - Cleared on pop or when count==0.
  - Otherwise, +1 per cycle the head is not popped, saturating at MAX_WAIT.
- States are registered. next = IDLE if count_next==0. Else FORCE if count_next==DEPTH or wait_cnt_next==MAX_WAIT. Else SERVE.
  - IDLE: lookup_grant=lookup_req; mem_en=lookup_req; no writes.
  - SERVE: if lookup_req, grant the read; else write the head.
  - FORCE: write the head; lookup_grant=0; fetch_stall=lookup_req. Exactly one forced write per FORCE cycle, then re-evaluate. FORCE persists only while the full/timeout condition re-holds.
- fetch_stall is 0 outside FORCE.
- pending_cnt = count (registered).
- Writes strictly in arrival order. Duplicate indices are not coalesced.

Test Plan:
1. Reset, lookup_req=0. Push pc=0x0006, taken=1, target=0x0020, wen_btb=1 -> next cycle: mem_en=1, mem_bht_we=1, mem_btb_we=1, mem_idx=3, mem_taken=1, mem_target=0x0020. pending_cnt goes 1 then 0.
2. lookup_req held 1, one update pushed (MAX_WAIT=4) -> lookup_grant=1 for 4 cycles. Then one FORCE cycle: mem_bht_we=1, lookup_grant=0, fetch_stall=1. Next cycle: lookup_grant=1, state IDLE.
3. lookup_req=1, 5 back-to-back updates (DEPTH=4) -> upd_ready=0 after the 4th push and the 5th is held. FORCE drains entries in push order. upd_ready returns 1 the cycle after the first pop, and the 5th is accepted.
4. count=2, lookup_req=0, push a new update in the same cycle as a pop -> pending_cnt stays 2. Subsequent writes come out in push order across pointer wrap.
5. Push with upd_wen_btb=0, taken=0, pc=0x000E -> write cycle: mem_bht_we=1, mem_btb_we=0, mem_idx=7, mem_taken=0.
6. 3 entries pending, rst_n pulsed low mid-cycle -> mem_en, upd_ready and pending_cnt all 0 immediately (asynchronously). After release, no write of the discarded entries ever appears.
